// File: rtl/ysyx_22041752_dbus_router_if.sv
// Bus bundles around the data-side router: EXU request port, CLINT port and
// the AXI arbiter data port. Each bundle has a master and a slave view.

interface ysyx_22041752_cpu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int WEN_W  = 8
);
   logic              cpu_en;
   logic [WEN_W-1:0]  cpu_wen;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ready;
   logic [DATA_W-1:0] cpu_rdata;
   logic              bus_err;

   modport master (
      output cpu_en, cpu_wen, cpu_addr, cpu_wdata,
      input  cpu_ready, cpu_rdata, bus_err
   );
   modport slave (
      input  cpu_en, cpu_wen, cpu_addr, cpu_wdata,
      output cpu_ready, cpu_rdata, bus_err
   );
endinterface

interface ysyx_22041752_clint_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic              clint_en;
   logic              clint_wen;
   logic [ADDR_W-1:0] clint_addr;
   logic [DATA_W-1:0] clint_wdata;
   logic [DATA_W-1:0] clint_rdata;
   logic              clint_rdat_v;

   modport master (
      output clint_en, clint_wen, clint_addr, clint_wdata,
      input  clint_rdata, clint_rdat_v
   );
   modport slave (
      input  clint_en, clint_wen, clint_addr, clint_wdata,
      output clint_rdata, clint_rdat_v
   );
endinterface

interface ysyx_22041752_mem_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int WEN_W  = 8
);
   logic              mem_en;
   logic [WEN_W-1:0]  mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_en, mem_wen, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );
   modport slave (
      input  mem_en, mem_wen, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/ysyx_22041752_dbus_router.sv
// Data-side router: latches one EXU request, steers it to exactly one of CLINT or
// the arbiter, returns one cpu_ready pulse. Optional counters: YSYX_22041752_DBUS_STAT_EN.
//
// Handshakes: EXU holds cpu_en and its fields until cpu_ready (one cycle, with
// cpu_rdata/bus_err); cpu_en is sampled only in IDLE, so the EXU drops it in the
// ready cycle unless it means a new request. clint_en is a one-cycle strobe answered
// by clint_rdat_v (reads only); mem_en is level-held until mem_ready is sampled high.

module ysyx_22041752_dbus_router #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 64,
   parameter int                WEN_W      = 8,
   parameter logic [ADDR_W-1:0] CLINT_BASE = 32'h0200_0000,
   parameter logic [ADDR_W-1:0] CLINT_MASK = 32'hFFFF_0000,
   parameter int                CLINT_TMO  = 15
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   ysyx_22041752_cpu_if.slave    cpu,
   ysyx_22041752_clint_if.master clint,
   ysyx_22041752_mem_if.master   mem,
   output logic [2:0]            dbg_state_o
`ifdef YSYX_22041752_DBUS_STAT_EN
   ,
   output logic [31:0]           stat_clint_cnt,
   output logic [31:0]           stat_mem_cnt,
   output logic [31:0]           stat_tmo_cnt
`endif
);

   if (WEN_W * 8 != DATA_W) begin : g_width_check
      $error("ysyx_22041752_dbus_router: WEN_W*8 must equal DATA_W");
   end

   localparam int                TMO_W    = $clog2(CLINT_TMO + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(CLINT_TMO - 1);
   localparam logic [TMO_W-1:0]  TMO_MAX  = {TMO_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_CLINT_REQ  = 3'd1,
      S_CLINT_WAIT = 3'd2,
      S_MEM_REQ    = 3'd3,
      S_DONE       = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [WEN_W-1:0]  wen_q, wen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              hit_q, hit_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              is_write;
   logic              addr_hit;

   assign is_write = |wen_q;
   assign addr_hit = (cpu.cpu_addr & CLINT_MASK) == CLINT_BASE;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         wen_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         hit_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         hit_q   <= hit_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      hit_d   = hit_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (cpu.cpu_en) begin
               // The decode is taken from the very value being latched.
               wen_d   = cpu.cpu_wen;
               addr_d  = cpu.cpu_addr;
               wdata_d = cpu.cpu_wdata;
               rdata_d = '0;
               err_d   = 1'b0;
               hit_d   = addr_hit;
               state_d = addr_hit ? S_CLINT_REQ : S_MEM_REQ;
            end
         end
         S_CLINT_REQ: begin
            if (is_write) begin
               state_d = S_DONE;
            end else begin
               tmo_d   = '0;
               state_d = S_CLINT_WAIT;
            end
         end
         S_CLINT_WAIT: begin
            if (clint.clint_rdat_v) begin
               rdata_d = clint.clint_rdata;
               state_d = S_DONE;
            end else if (tmo_q == TMO_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (tmo_q != TMO_MAX) begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_MEM_REQ: begin
            if (mem.mem_ready) begin
               rdata_d = is_write ? '0 : mem.mem_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Strobes are pure decodes of the state register, so they are glitch-free,
   // mutually exclusive, and fall immediately on reset.
   assign clint.clint_en    = (state_q == S_CLINT_REQ);
   assign clint.clint_wen   = is_write;
   assign clint.clint_addr  = addr_q;
   assign clint.clint_wdata = wdata_q;

   assign mem.mem_en    = (state_q == S_MEM_REQ);
   assign mem.mem_wen   = wen_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   assign cpu.cpu_ready = (state_q == S_DONE);
   assign cpu.cpu_rdata = rdata_q;
   assign cpu.bus_err   = (state_q == S_DONE) && err_q;

   assign dbg_state_o = state_q;

`ifdef YSYX_22041752_DBUS_STAT_EN
   logic [31:0] stat_clint_q;
   logic [31:0] stat_mem_q;
   logic [31:0] stat_tmo_q;

   // A timeout is still a CLINT transaction, so it bumps both counters.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         stat_clint_q <= '0;
         stat_mem_q   <= '0;
         stat_tmo_q   <= '0;
      end else if (state_q == S_DONE) begin
         if (hit_q) begin
            stat_clint_q <= stat_clint_q + 32'd1;
         end else begin
            stat_mem_q <= stat_mem_q + 32'd1;
         end
         if (err_q) begin
            stat_tmo_q <= stat_tmo_q + 32'd1;
         end
      end
   end

   assign stat_clint_cnt = stat_clint_q;
   assign stat_mem_cnt   = stat_mem_q;
   assign stat_tmo_cnt   = stat_tmo_q;
`endif

endmodule

// File: tb/tb_ysyx_22041752_dbus_router.sv
// Directed bench for the data-side router: drivers issue requests and push the
// expected response; a monitor pops and compares on every cpu_ready pulse.

module tb_ysyx_22041752_dbus_router;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 64;
   localparam int WEN_W     = 8;
   localparam int CLINT_TMO = 15;
   localparam int RW        = DATA_W + 1;

   // ---------------- clock / reset ----------------
   logic aclk    = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   logic [2:0] dbg_state;

   ysyx_22041752_cpu_if   #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WEN_W(WEN_W)) cpu_bus ();
   ysyx_22041752_clint_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W))                 clint_bus ();
   ysyx_22041752_mem_if   #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WEN_W(WEN_W)) mem_bus ();

`ifdef YSYX_22041752_DBUS_STAT_EN
   logic [31:0] stat_clint_cnt, stat_mem_cnt, stat_tmo_cnt;
`endif

   ysyx_22041752_dbus_router #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .WEN_W     (WEN_W),
      .CLINT_BASE(32'h0200_0000),
      .CLINT_MASK(32'hFFFF_0000),
      .CLINT_TMO (CLINT_TMO)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .cpu        (cpu_bus),
      .clint      (clint_bus),
      .mem        (mem_bus),
      .dbg_state_o(dbg_state)
`ifdef YSYX_22041752_DBUS_STAT_EN
      ,
      .stat_clint_cnt(stat_clint_cnt),
      .stat_mem_cnt  (stat_mem_cnt),
      .stat_tmo_cnt  (stat_tmo_cnt)
`endif
   );

   // ---------------- scoreboard ----------------
   int              n_tests = 0;
   int              n_fail  = 0;
   logic [RW-1:0]   exp_q[$];
   logic [RW-1:0]   mon_exp;

   task automatic check_bit(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", nm, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic check_val(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every completion pulse must match the oldest outstanding expectation.
   always @(negedge aclk) begin
      if (aresetn && cpu_bus.cpu_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ready: got rdata 0x%0h with no request outstanding",
                     cpu_bus.cpu_rdata);
         end else begin
            mon_exp = exp_q.pop_front();
            check_val("response{err,rdata}", {cpu_bus.bus_err, cpu_bus.cpu_rdata}, mon_exp);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge aclk);
   endtask

   // Issues one request at the current negedge and acts as both targets.
   // resp_dly: CLINT -> cycles after clint_en to assert clint_rdat_v (0 = never);
   //           mem   -> mem_en cycle index in which mem_ready is asserted.
   // The target not addressed answers spuriously for the whole transaction.
   task automatic run_txn(input string nm, input logic [31:0] addr, input logic [7:0] wen,
                          input logic [63:0] wdata, input int resp_dly,
                          input logic [63:0] resp_data, input bit is_clint,
                          input logic [63:0] exp_rdata, input bit exp_err,
                          input int exp_lat, input bit keep_en);
      int lat          = 0;
      int clint_pulses = 0;
      int clint_at     = -1;
      int mem_cycles   = 0;
      int overlap      = 0;
      int bad_fields   = 0;
      bit done         = 1'b0;
      cpu_bus.cpu_en    = 1'b1;
      cpu_bus.cpu_wen   = wen;
      cpu_bus.cpu_addr  = addr;
      cpu_bus.cpu_wdata = wdata;
      exp_q.push_back({exp_err, exp_rdata});
      if (is_clint) begin
         mem_bus.mem_ready     = 1'b1;
         mem_bus.mem_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
         clint_bus.clint_rdata = resp_data;
      end else begin
         clint_bus.clint_rdat_v = 1'b1;
         clint_bus.clint_rdata  = 64'hBAD1_BAD1_BAD1_BAD1;
         mem_bus.mem_rdata      = resp_data;
      end
      while (!done && lat < 64) begin
         @(negedge aclk);
         lat++;
         if (clint_bus.clint_en && mem_bus.mem_en) overlap++;
         if (clint_bus.clint_en) begin
            clint_pulses++;
            clint_at = lat;
            if (clint_bus.clint_wen !== (|wen) || clint_bus.clint_addr !== addr ||
                clint_bus.clint_wdata !== wdata) bad_fields++;
         end
         if (mem_bus.mem_en) begin
            mem_cycles++;
            if (mem_bus.mem_wen !== wen || mem_bus.mem_addr !== addr ||
                mem_bus.mem_wdata !== wdata) bad_fields++;
         end
         if (is_clint) begin
            clint_bus.clint_rdat_v = (resp_dly > 0) && (clint_at > 0) && (lat == clint_at + resp_dly);
         end else begin
            mem_bus.mem_ready = mem_bus.mem_en && (mem_cycles == resp_dly);
         end
         if (cpu_bus.cpu_ready) begin
            done = 1'b1;
            if (!keep_en) cpu_bus.cpu_en = 1'b0;
         end
      end
      mem_bus.mem_ready      = 1'b0;
      clint_bus.clint_rdat_v = 1'b0;
      check_bit({nm, "_ready_seen"}, done, 1'b1);
      check_int({nm, "_latency"}, lat, exp_lat);
      check_int({nm, "_clint_en_pulses"}, clint_pulses, is_clint ? 1 : 0);
      check_int({nm, "_mem_en_cycles"}, mem_cycles, is_clint ? 0 : resp_dly);
      check_int({nm, "_target_overlap"}, overlap, 0);
      check_int({nm, "_latched_fields_bad"}, bad_fields, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int waited;
      cpu_bus.cpu_en         = 1'b0;
      cpu_bus.cpu_wen        = '0;
      cpu_bus.cpu_addr       = '0;
      cpu_bus.cpu_wdata      = '0;
      clint_bus.clint_rdata  = '0;
      clint_bus.clint_rdat_v = 1'b0;
      mem_bus.mem_ready      = 1'b0;
      mem_bus.mem_rdata      = '0;

      idle(3);
      check_bit("rst_cpu_ready", cpu_bus.cpu_ready, 1'b0);
      check_bit("rst_bus_err", cpu_bus.bus_err, 1'b0);
      check_bit("rst_clint_en", clint_bus.clint_en, 1'b0);
      check_bit("rst_clint_wen", clint_bus.clint_wen, 1'b0);
      check_bit("rst_mem_en", mem_bus.mem_en, 1'b0);
      check_int("rst_mem_wen", int'(mem_bus.mem_wen), 0);
      check_int("rst_state", int'(dbg_state), 0);
      check_val("rst_cpu_rdata", {1'b0, cpu_bus.cpu_rdata}, '0);
      aresetn = 1'b1;
      idle(2);

      // name, addr, wen, wdata, resp_dly, resp_data, is_clint, exp_rdata, exp_err, exp_lat, keep_en
      run_txn("clint_wr", 32'h0200_4000, 8'hFF, 64'h1234, 0, 64'h0, 1'b1, 64'h0, 1'b0, 2, 1'b0);
      idle(1);
      run_txn("clint_rd", 32'h0200_BFF8, 8'h00, 64'h0, 1, 64'hABCD, 1'b1, 64'hABCD, 1'b0, 3, 1'b0);
      idle(1);
      run_txn("clint_rd_slow", 32'h0200_0100, 8'h00, 64'h0, 4, 64'h5555_AAAA_0000_FFFF,
              1'b1, 64'h5555_AAAA_0000_FFFF, 1'b0, 6, 1'b0);
      idle(1);
      run_txn("clint_tmo", 32'h0200_0008, 8'h00, 64'h0, 0, 64'h0, 1'b1, 64'h0, 1'b1,
              2 + CLINT_TMO, 1'b0);
      idle(1);
      run_txn("mem_rd", 32'h8000_0010, 8'h00, 64'h0, 5, 64'hDEAD_BEEF, 1'b0,
              64'hDEAD_BEEF, 1'b0, 6, 1'b0);
      idle(1);
      run_txn("mem_rd_edge", 32'h0201_0000, 8'h00, 64'h0, 1, 64'h0123_4567_89AB_CDEF, 1'b0,
              64'h0123_4567_89AB_CDEF, 1'b0, 2, 1'b0);
      idle(1);
      run_txn("mem_wr", 32'h01FF_FFF8, 8'h0F, 64'hCAFE_F00D, 3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              64'h0, 1'b0, 4, 1'b0);
      idle(1);
      run_txn("clint_wr_top", 32'h0200_FFFF, 8'h01, 64'h42, 0, 64'h0, 1'b1, 64'h0, 1'b0, 2, 1'b0);
      idle(1);

      // Back-to-back: the second request is set up in the ready cycle with cpu_en held,
      // so one extra cycle (the IDLE accept) precedes its normal CLINT read latency.
      run_txn("b2b_mem_wr", 32'h8000_0100, 8'hFF, 64'h1111_2222, 2, 64'h0, 1'b0, 64'h0, 1'b0, 3, 1'b1);
      run_txn("b2b_clint_rd", 32'h0200_BFF8, 8'h00, 64'h0, 1, 64'h77, 1'b1, 64'h77, 1'b0, 4, 1'b0);
      idle(2);

      // Reset while the arbiter request is pending.
      cpu_bus.cpu_en    = 1'b1;
      cpu_bus.cpu_wen   = 8'h00;
      cpu_bus.cpu_addr  = 32'h8000_0040;
      cpu_bus.cpu_wdata = 64'h0;
      waited = 0;
      while (!mem_bus.mem_en && waited < 10) begin
         @(negedge aclk);
         waited++;
      end
      check_bit("mid_rst_mem_en_rose", mem_bus.mem_en, 1'b1);
      idle(1);
      #2;
      aresetn = 1'b0;
      #1;
      check_bit("mid_rst_mem_en", mem_bus.mem_en, 1'b0);
      check_bit("mid_rst_cpu_ready", cpu_bus.cpu_ready, 1'b0);
      check_int("mid_rst_state", int'(dbg_state), 0);
      cpu_bus.cpu_en = 1'b0;
      idle(2);
      aresetn = 1'b1;
      idle(1);
      check_int("post_rst_state", int'(dbg_state), 0);
      check_bit("post_rst_mem_en", mem_bus.mem_en, 1'b0);
      run_txn("post_rst_mem_rd", 32'h8000_0040, 8'h00, 64'h0, 2, 64'h600D, 1'b0,
              64'h600D, 1'b0, 3, 1'b0);
      idle(3);

      check_int("outstanding_expectations", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ysyx_22041752_dbus_router.md
Name: ysyx_22041752_dbus_router

Overview:
Data-side bus controller between the EXU data port and two targets: the CLINT and the AXI arbiter's data channel. It latches each EXU request and decodes the address to pick one target. It issues the request using that target's protocol, waits for completion, and returns a single registered ready/rdata pulse to the EXU. It replaces the direct fan-out and the `clint_rdat_v` read-data mux at top level, and it guarantees exactly one target per transaction.

Parameters:
ADDR_W, 32, address width.
DATA_W, 64, data width.
WEN_W, 8, byte write-enable width (DATA_W/8).
CLINT_BASE, 32'h0200_0000, CLINT region base.
CLINT_MASK, 32'hFFFF_0000, decode mask; the target is CLINT iff (addr & CLINT_MASK) == CLINT_BASE.
CLINT_TMO, 15, maximum cycles to wait for `clint_rdat_v` on a read.

Ports:
aclk  in  1  clock, rising edge.
aresetn  in  1  asynchronous active-low reset.
cpu_en  in  1  request valid; held by the EXU until cpu_ready.
cpu_wen  in  WEN_W  byte write enables; zero means read.
cpu_addr  in  ADDR_W  request address.
cpu_wdata  in  DATA_W  write data.
cpu_ready  out  1  one-cycle completion pulse.
cpu_rdata  out  DATA_W  read data, valid while cpu_ready is high.
bus_err  out  1  one-cycle pulse together with cpu_ready on a CLINT timeout.
clint_en  out  1  one-cycle CLINT access strobe.
clint_wen  out  1  CLINT write (OR of the latched wen).
clint_addr  out  ADDR_W  latched address.
clint_wdata  out  DATA_W  latched write data.
clint_rdata  in  DATA_W  CLINT read data.
clint_rdat_v  in  1  CLINT read data valid.
mem_en  out  1  arbiter data request, level-held.
mem_wen  out  WEN_W  latched wen.
mem_addr  out  ADDR_W  latched address.
mem_wdata  out  DATA_W  latched write data.
mem_ready  in  1  arbiter completion.
mem_rdata  in  DATA_W  arbiter read data.

Behaviour:
- Clock and reset: one clock, aclk. Reset is aresetn, asynchronous and active-low.
- Reset values: state = IDLE; cpu_ready, bus_err, clint_en, clint_wen, mem_en = 0; mem_wen = 0. All data/address registers = 0; tmo_cnt = 0.
- FSM states: IDLE, CLINT_REQ, CLINT_WAIT, MEM_REQ, DONE.
- IDLE:
  - cpu_en sampled only here. On cpu_en, latch wen/addr/wdata and decode.
  - CLINT hit → CLINT_REQ; otherwise → MEM_REQ.
  - cpu_ready = 0.
- CLINT_REQ: clint_en = 1 for exactly this cycle.
  - Write → DONE.
  - Read → CLINT_WAIT with tmo_cnt cleared.
- CLINT_WAIT:
  - On clint_rdat_v: capture clint_rdata → DONE.
  - Otherwise tmo_cnt increments. When tmo_cnt == CLINT_TMO-1 without valid: rdata = 0, set the err flag → DONE.
  - tmo_cnt saturates and never wraps.
- MEM_REQ: mem_en held high.
  - On a cycle with mem_ready = 1: capture mem_rdata → DONE.
  - mem_en drops in the DONE cycle.
  - No timeout on this path.
- DONE: cpu_ready = 1 for one cycle, with bus_err = err flag. Err flag cleared. → IDLE.
- Writes return cpu_rdata = 0.
- Latency, from accept cycle c0 (IDLE with cpu_en):
  - CLINT write: ready at c2.
  - CLINT read with valid in the cycle after clint_en: ready at c3.
  - Mem: ready one cycle after mem_ready is sampled.
- Back-to-back: if cpu_en is still high in the IDLE cycle after DONE, it is treated as a new request. The EXU must drop en in the cpu_ready cycle to avoid a repeat.
- Request changes while busy are ignored; the latched copy is authoritative.
- Spurious inputs: clint_rdat_v and mem_ready are ignored outside their wait states. The router never drives clint_en and mem_en in the same cycle.
- Reset mid-transaction: immediate return to IDLE with outputs at reset values. mem_en drops asynchronously; the arbiter shares the reset domain.
- Address decode covers only the latched address. Width mismatch is not permitted: WEN_W*8 == DATA_W.

Optional Feature:
YSYX_22041752_DBUS_STAT_EN.
- Defined: adds outputs stat_clint_cnt, stat_mem_cnt and stat_tmo_cnt (32 bits each, reset 0). Each increments by one on the DONE cycle of the matching transaction type; timeouts count both clint and tmo. Each counter wraps 32'hFFFF_FFFF → 0.
- Undefined: no ports, no counters. Functional behaviour is identical.

Test Plan:
- CLINT write: addr 0x0200_4000, wen 8'hFF, wdata 0x1234 → clint_en pulses once at c1 with clint_wen = 1; cpu_ready at c2; rdata 0; mem_en never rises.
- CLINT read: addr 0x0200_BFF8; bench drives clint_rdat_v with 0xABCD one cycle after clint_en → cpu_ready at c3; cpu_rdata 0xABCD; bus_err 0.
- CLINT read timeout: clint_rdat_v held 0 → cpu_ready exactly CLINT_TMO cycles after CLINT_WAIT entry; bus_err = 1; rdata 0.
- Mem read: addr 0x8000_0010, mem_ready asserted 5 cycles after mem_en with rdata 0xDEAD_BEEF → mem_en high for 5 cycles then low; cpu_ready one cycle later with 0xDEAD_BEEF.
- Back-to-back: mem write then CLINT read with cpu_en held → second request accepted in the IDLE cycle after DONE; targets never overlap.
- Reset mid-MEM_REQ: aresetn low while mem_en = 1 → mem_en, cpu_ready = 0 immediately. After release, FSM is IDLE and a fresh request completes normally.
